mv_max_scan_ctrl: RTL
=====================

# mv_max_scan_ctrl

Scan controller that drives the running-maximum finder in the detection back end. On a start pulse it clears the finder, walks a score RAM from address 0 to N-1, and streams each (position, score) pair into the finder. Once the last pair has settled, it captures the finder's maximum value and position and holds them as a result for the face-selection logic under a valid/ready handshake.

## Interface
- POS_W, 13, width of position/address
- DATA_W, 32, width of score (unsigned)

Ports:
- iClk  in  1  clock
- iReset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- iStart  in  1  start pulse; sampled only in IDLE
- iNum_pos  in  POS_W  number of positions N to scan; latched on accepted start
- oRd_en  out  1  score RAM read enable
- oRd_addr  out  POS_W  score RAM address
- iRd_data  in  DATA_W  score RAM data, valid exactly 1 cycle after oRd_en
- oRst_reg  out  1  one-cycle clear to the finder
- oPosition  out  POS_W  position presented to the finder
- oData  out  DATA_W  score presented to the finder; 0 when no valid pair
- iMax_val  in  DATA_W  finder running maximum (registered in the finder)
- iMax_pos  in  POS_W  finder running max position
- oBusy  out  1  high in every state except IDLE
- oDone_valid  out  1  result valid
- iDone_ready  in  1  consumer accepts result
- oResult_val  out  DATA_W  captured maximum
- oResult_pos  out  POS_W  captured position
- oFound  out  1  result qualifies (see Configuration)

## Operation
- States: IDLE, CLEAR, READ, DRAIN, WAIT, HOLD.
- IDLE: when iStart=1, latch iNum_pos into N and go to CLEAR. iStart in any other state is ignored.
- CLEAR: oRst_reg=1 for exactly this cycle. If N=0, go to WAIT; otherwise go to READ with the address counter at 0.
- READ: oRd_en=1 and oRd_addr=counter. The counter increments each cycle. After issuing address N-1, go to DRAIN.
- Stream: a 1-cycle-delayed copy of the address and read valid. In the cycle after a read, oPosition is the delayed address and oData is iRd_data. In all other cycles oData=0, which is never strictly greater than the finder's maximum, so idle cycles are harmless.
- DRAIN: presents the last pair and issues no read. Go to WAIT.
- WAIT: the finder outputs are final. Capture iMax_val into oResult_val.
  - If iMax_val=0 (including N=0), force oResult_pos=0 because the finder's position is not cleared.
  - Otherwise capture iMax_pos into oResult_pos.
  - Go to HOLD.
- HOLD: oDone_valid=1. Result outputs are stable while oDone_valid=1. When iDone_ready=1, go to IDLE on the next cycle.
- Ties: the finder keeps the first occurrence; this block imposes no extra tie rule.
- Reset in any state: synchronous return to IDLE on the next edge; every output takes its reset value.

## Timing
- Reset values: oRd_en=0, oRd_addr=0, oRst_reg=0, oPosition=0, oData=0, oBusy=0, oDone_valid=0, oResult_val=0, oResult_pos=0, oFound=0.
- Cycle numbering: start sampled at cycle 0.
  - CLEAR is cycle 1.
  - Reads occur in cycles 2..N+1.
  - Pairs are presented in cycles 3..N+2.
  - WAIT is cycle N+3.
  - oDone_valid rises at cycle N+4.
- N=0: oDone_valid rises at cycle 3.
- Handshake transfer happens on a cycle with oDone_valid and iDone_ready both high. oDone_valid is 0 on the following cycle.
- The earliest next iStart is accepted in the IDLE cycle after the transfer.
- N=2^POS_W−1 (8191 at default): the counter must not wrap before DRAIN. Compare the counter against N−1; do not rely on overflow.

## Configuration
- MV_SCAN_THRESH_EN defined:
  - Adds input iThreshold (DATA_W).
  - oFound is captured in WAIT as (iMax_val > iThreshold).
  - oResult_val and oResult_pos are still reported.
- Not defined: there is no iThreshold port, and oFound is captured as (iMax_val != 0).

## Structure
- Package mv_scan_pkg contains:
  - the state enum;
  - constants POS_W_DEF=13 and DATA_W_DEF=32.
- Sub-module mv_scan_addr_gen contains the address counter, the terminal-count compare against N−1, and the 1-cycle delayed address/valid used for oPosition/oData.
- FSM and result capture stay in the top module.

## Test plan
- N=4, RAM={5,9,3,7}: 1-cycle oRst_reg at cycle 1; result 9 at pos 1; oDone_valid at cycle 8; oFound=1.
- N=3, RAM={4,4,2}: tie resolves to the first occurrence, result 4 at pos 0.
- N=0, and separately N=3 with RAM all 0: result 0, pos 0, oFound=0. For N=0, oDone_valid at cycle 3.
- iDone_ready held low for 10 cycles: result and oDone_valid stable; a second iStart during HOLD is ignored; after ready, a new start runs normally.
- iReset asserted mid-READ: all outputs take reset values on the next cycle. A restart with N=2 and RAM={1,6} then returns 6 at pos 1.
- MV_SCAN_THRESH_EN defined, iThreshold=9, max 9: oFound=0. With max 10: oFound=1.

Source files
------------

// File: rtl/mv_scan_pkg.sv
// Shared types and default widths for the max-scan controller.
// Optional threshold qualification is enabled by defining MV_SCAN_THRESH_EN.
package mv_scan_pkg;

    localparam int unsigned POS_W_DEF  = 13;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRead,
        StDrain,
        StWait,
        StHold
    } scan_state_e;

endpackage

// File: rtl/mv_scan_addr_gen.sv
// Score RAM address counter with terminal-count detect and a one-cycle
// delayed address/valid pair that feeds the finder stream.
module mv_scan_addr_gen
    import mv_scan_pkg::*;
#(
    parameter int unsigned POS_W = POS_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_read,
    input  logic [POS_W-1:0] i_num,
    output logic [POS_W-1:0] o_addr,
    output logic             o_last,
    output logic [POS_W-1:0] o_pos,
    output logic             o_valid
);

    logic [POS_W-1:0] r_cnt;
    logic [POS_W-1:0] r_pos;
    logic             r_valid;
    logic [POS_W-1:0] w_num_m1;

    // Explicit compare against N-1 so N = 2^POS_W-1 never relies on wrap-around.
    assign w_num_m1 = i_num - POS_W'(1);
    assign o_last   = (r_cnt == w_num_m1);
    assign o_addr   = r_cnt;
    assign o_pos    = r_pos;
    assign o_valid  = r_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_pos   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (i_clear) begin
                r_cnt <= '0;
            end else if (i_read && !o_last) begin
                r_cnt <= r_cnt + POS_W'(1);
            end
            r_valid <= i_read;
            r_pos   <= i_read ? r_cnt : '0;
        end
    end

endmodule

// File: rtl/mv_max_scan_ctrl.sv
// Scan controller: clears the max finder, streams the score RAM into it and
// holds the captured maximum under valid/ready. Define MV_SCAN_THRESH_EN for iThreshold.
module mv_max_scan_ctrl
    import mv_scan_pkg::*;
#(
    parameter int unsigned POS_W  = POS_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iStart,
    input  logic [POS_W-1:0]  iNum_pos,
    output logic              oRd_en,
    output logic [POS_W-1:0]  oRd_addr,
    input  logic [DATA_W-1:0] iRd_data,
    output logic              oRst_reg,
    output logic [POS_W-1:0]  oPosition,
    output logic [DATA_W-1:0] oData,
    input  logic [DATA_W-1:0] iMax_val,
    input  logic [POS_W-1:0]  iMax_pos,
`ifdef MV_SCAN_THRESH_EN
    input  logic [DATA_W-1:0] iThreshold,
`endif
    output logic              oBusy,
    output logic              oDone_valid,
    input  logic              iDone_ready,
    output logic [DATA_W-1:0] oResult_val,
    output logic [POS_W-1:0]  oResult_pos,
    output logic              oFound
);

    scan_state_e       r_state;
    logic [POS_W-1:0]  r_num;
    logic              r_rd_en;
    logic              r_rst_reg;
    logic              r_busy;
    logic              r_done_valid;
    logic [DATA_W-1:0] r_result_val;
    logic [POS_W-1:0]  r_result_pos;
    logic              r_found;

    logic              w_clear;
    logic              w_last;
    logic [POS_W-1:0]  w_addr;
    logic [POS_W-1:0]  w_pos;
    logic              w_valid;
    logic              w_found;

    assign w_clear = (r_state == StClear);

    mv_scan_addr_gen #(
        .POS_W (POS_W)
    ) u_addr_gen (
        .i_clk   (iClk),
        .i_reset (iReset),
        .i_clear (w_clear),
        .i_read  (r_rd_en),
        .i_num   (r_num),
        .o_addr  (w_addr),
        .o_last  (w_last),
        .o_pos   (w_pos),
        .o_valid (w_valid)
    );

`ifdef MV_SCAN_THRESH_EN
    assign w_found = (iMax_val > iThreshold);
`else
    assign w_found = (iMax_val != '0);
`endif

    // Zero data outside valid pairs can never beat the finder's maximum.
    assign oData       = w_valid ? iRd_data : '0;
    assign oPosition   = w_pos;
    assign oRd_en      = r_rd_en;
    assign oRd_addr    = w_addr;
    assign oRst_reg    = r_rst_reg;
    assign oBusy       = r_busy;
    assign oDone_valid = r_done_valid;
    assign oResult_val = r_result_val;
    assign oResult_pos = r_result_pos;
    assign oFound      = r_found;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            r_state      <= StIdle;
            r_num        <= '0;
            r_rd_en      <= 1'b0;
            r_rst_reg    <= 1'b0;
            r_busy       <= 1'b0;
            r_done_valid <= 1'b0;
            r_result_val <= '0;
            r_result_pos <= '0;
            r_found      <= 1'b0;
        end else begin
            r_rst_reg <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (iStart) begin
                        r_num     <= iNum_pos;
                        r_rst_reg <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= StClear;
                    end
                end
                StClear: begin
                    if (r_num == '0) begin
                        r_state <= StWait;
                    end else begin
                        r_rd_en <= 1'b1;
                        r_state <= StRead;
                    end
                end
                StRead: begin
                    if (w_last) begin
                        r_rd_en <= 1'b0;
                        r_state <= StDrain;
                    end
                end
                StDrain: begin
                    r_state <= StWait;
                end
                StWait: begin
                    // The finder never clears its position, so an all-zero scan reports 0.
                    r_result_val <= iMax_val;
                    r_result_pos <= (iMax_val == '0) ? '0 : iMax_pos;
                    r_found      <= w_found;
                    r_done_valid <= 1'b1;
                    r_state      <= StHold;
                end
                StHold: begin
                    if (iDone_ready) begin
                        r_done_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= StIdle;
                    end
                end
                default: begin
                    r_rd_en      <= 1'b0;
                    r_busy       <= 1'b0;
                    r_done_valid <= 1'b0;
                    r_state      <= StIdle;
                end
            endcase
        end
    end

endmodule
